ifu_refill_arb: RTL and testbench
=================================

// Module: ifu_refill_arb
// PURPOSE
//  Sequences line refills for ifu_cache: arbitrates cache demand misses against prefetcher requests for the single
//  memory request port, keeps one refill in flight, and retries on timeout. Delivers each returned line to the cache
//  fill port as a one-cycle pulse. Sits between ifu_cache/prefetcher and the memory interface.
// PARAMETERS
//  TAG_WIDTH      28   line tag width (address bits above line offset)
//  LINE_WIDTH     128  instruction line width
//  STARVE_LIMIT   4    consecutive demand grants with prefetch pending before prefetch wins once (>=1)
//  TIMEOUT_CYCLES 64   WAIT cycles without matching response before reissue (>=2)
//  MAX_RETRY      2    reissues allowed per refill before error
// PORTS
//  Clock             in  1           clock
//  Rst               in  1           synchronous reset, active-low
//  dmd_reqTagIn      in  TAG_WIDTH   cache miss tag
//  dmd_reqValidIn    in  1           level: cache miss pending
//  pf_reqTagIn       in  TAG_WIDTH   prefetch tag
//  pf_reqValidIn     in  1           prefetch request, held until pf_reqAckOut
//  pf_reqAckOut      out 1           pulse: prefetch accepted (granted or merged)
//  mem_reqTagOut     out TAG_WIDTH   tag requested from memory
//  mem_reqValidOut   out 1           memory request valid
//  mem_reqReadyIn    in  1           memory accepts request when valid&ready
//  mem_rspTagIn      in  TAG_WIDTH   response tag
//  mem_rspLineIn     in  LINE_WIDTH  response line
//  mem_rspValidIn    in  1           response valid
//  fill_tagOut       out TAG_WIDTH   tag of line to insert
//  fill_lineOut      out LINE_WIDTH  line to insert
//  fill_validOut     out 1           pulse: cache inserts line this cycle
//  fill_isPfOut      out 1           fill originated from prefetch
//  busyOut           out 1           state != IDLE
//  timeoutErrOut     out 1           sticky: refill exceeded MAX_RETRY
// BEHAVIOUR
//  Reset (Rst==0 at posedge): state IDLE; all outputs 0; starve/timeout/retry counters 0; timeoutErrOut cleared.
//  Reset mid-refill abandons it; late responses after reset are ignored (no fill).
//  FSM: IDLE -> REQ -> WAIT -> FILL -> IDLE.
//  IDLE: grant if any valid. Demand wins unless prefetch valid and starveCnt==STARVE_LIMIT, then prefetch wins and
//   starveCnt<=0. starveCnt++ (saturating) on each demand grant while pf_reqValidIn=1; cleared when pf not pending.
//   Merge: pf_reqValidIn with pf_reqTagIn==granted/in-flight tag -> pf_reqAckOut pulse, no separate refill.
//   Prefetch grant -> pf_reqAckOut pulse same cycle as IDLE->REQ. Latch tag, source; go REQ next cycle.
//  REQ: mem_reqValidOut=1, mem_reqTagOut=latched tag, held stable until mem_reqReadyIn; on handshake -> WAIT,
//   timeout counter <=0.
//  WAIT: accept response only if mem_rspValidIn && mem_rspTagIn==latched tag; capture line -> FILL.
//   Non-matching responses dropped. Counter++ per cycle; at TIMEOUT_CYCLES-1 with no match: retry<MAX_RETRY ->
//   retry++, back to REQ; else timeoutErrOut<=1, refill dropped -> IDLE. Match on the timeout cycle wins.
//  FILL: fill_validOut=1 exactly one cycle with latched tag/line, fill_isPfOut=source; -> IDLE, retry<=0.
//  Latency, demand miss uncontended, ready=1, response N cycles after handshake: fill pulse at cycle N+3 after
//   dmd_reqValidIn first sampled (IDLE grant, REQ, WAIT..., FILL).
//  Demand tag changing while in flight: refill completes and fills anyway; new tag arbitrated from IDLE.
//  Demand still valid with same tag after FILL (cache hit not yet seen) is not re-requested in FILL->IDLE cycle:
//   IDLE ignores demand tag == last filled tag for one cycle.
//  Only one refill outstanding; no request issued while state != IDLE.
// TESTING
//  Demand tag 0x12 alone, ready=1, rsp 5 cycles later -> one mem req tag 0x12, one fill pulse, fill_isPfOut=0.
//  Demand and prefetch held continuously, distinct tags, STARVE_LIMIT=4 -> grant order D,D,D,D,P,D,D,D,D,P.
//  Prefetch tag equal to in-flight demand tag 0x40 -> pf_reqAckOut pulse, exactly one mem request, one fill.
//  No response, TIMEOUT_CYCLES=64, MAX_RETRY=2 -> 3 requests 64 cycles apart, then timeoutErrOut=1, IDLE, no fill.
//  Wrong-tag response 0x99 during WAIT for 0x12, then correct -> only 0x12 filled; mem_reqReadyIn=0 for 10 cycles
//   -> request held stable.
//  Rst low during WAIT, response arrives after -> all outputs 0, no fill, busyOut=0.

Source files
------------

// File: rtl/ifu_refill_arb.sv
// ifu_refill_arb: line-refill sequencer for ifu_cache.
// It arbitrates cache demand misses against prefetcher requests for the single
// memory request port and keeps at most one refill in flight. A refill that sees
// no response is reissued after a timeout. Each returned line is delivered to the
// cache fill port as a one-cycle pulse.
//
// Ports
//   Clock, Rst                  clock, synchronous active-low reset
//   dmd_reqTagIn/ValidIn        demand miss (level)
//   pf_reqTagIn/ValidIn         prefetch request, held until pf_reqAckOut
//   pf_reqAckOut                pulse: prefetch granted or merged
//   mem_req*                    memory request channel (valid/ready)
//   mem_rsp*                    memory response channel (tag-matched)
//   fill_*                      cache fill port; fill_validOut is a one-cycle pulse
//   busyOut                     refill sequencer not idle
//   timeoutErrOut               sticky: a refill ran out of retries
module ifu_refill_arb #(
    parameter int TAG_WIDTH      = 28,
    parameter int LINE_WIDTH     = 128,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  dmd_reqTagIn,
    input  logic                  dmd_reqValidIn,
    input  logic [TAG_WIDTH-1:0]  pf_reqTagIn,
    input  logic                  pf_reqValidIn,
    output logic                  pf_reqAckOut,
    output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
    output logic                  mem_reqValidOut,
    input  logic                  mem_reqReadyIn,
    input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0] mem_rspLineIn,
    input  logic                  mem_rspValidIn,
    output logic [TAG_WIDTH-1:0]  fill_tagOut,
    output logic [LINE_WIDTH-1:0] fill_lineOut,
    output logic                  fill_validOut,
    output logic                  fill_isPfOut,
    output logic                  busyOut,
    output logic                  timeoutErrOut
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 2);

    // The timeout counter starts at the request handshake, so the last WAIT cycle
    // is TIMEOUT_CYCLES-2; reissued handshakes then land TIMEOUT_CYCLES apart.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_LIMIT);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [TAG_WIDTH-1:0]   tag_s;
    logic                   src_pf_r;
    logic                   src_pf_s;
    logic [TO_W-1:0]        to_cnt_r;
    logic [TO_W-1:0]        to_cnt_s;
    logic [RT_W-1:0]        retry_r;
    logic [RT_W-1:0]        retry_s;
    logic [ST_W-1:0]        starve_r;
    logic [ST_W-1:0]        starve_s;
    logic [TAG_WIDTH-1:0]   last_tag_r;
    logic                   ign_r;
    logic                   ack_s;
    logic                   err_set_s;

    logic                   dmd_ok_s;
    logic                   pf_new_s;
    logic                   pick_p_s;
    logic                   pick_d_s;
    logic                   merge_busy_s;
    logic                   rsp_hit_s;

    // A demand for the line just filled is ignored in the first IDLE cycle: the
    // cache has not yet seen its own hit. A prefetch already acked last cycle is
    // not new, because the prefetcher only drops it after seeing the ack.
    assign dmd_ok_s     = dmd_reqValidIn && !(ign_r && (dmd_reqTagIn == last_tag_r));
    assign pf_new_s     = pf_reqValidIn && !pf_reqAckOut;
    assign pick_p_s     = (state_r == ST_IDLE) && pf_new_s && (!dmd_ok_s || (starve_r == ST_MAX));
    assign pick_d_s     = (state_r == ST_IDLE) && dmd_ok_s && !pick_p_s;
    assign merge_busy_s = (state_r != ST_IDLE) && pf_new_s && (pf_reqTagIn == tag_r);
    assign rsp_hit_s    = mem_rspValidIn && (mem_rspTagIn == tag_r);

    // Next-state, arbitration, merge-ack and counter updates.
    always_comb begin
        state_s   = state_r;
        tag_s     = tag_r;
        src_pf_s  = src_pf_r;
        to_cnt_s  = to_cnt_r;
        retry_s   = retry_r;
        ack_s     = merge_busy_s;
        err_set_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pick_p_s) begin
                    state_s  = ST_REQ;
                    tag_s    = pf_reqTagIn;
                    src_pf_s = 1'b1;
                    retry_s  = {RT_W{1'b0}};
                    ack_s    = 1'b1;
                end else if (pick_d_s) begin
                    state_s  = ST_REQ;
                    tag_s    = dmd_reqTagIn;
                    src_pf_s = 1'b0;
                    retry_s  = {RT_W{1'b0}};
                    // A prefetch for the same line rides along with the demand refill.
                    ack_s    = pf_new_s && (pf_reqTagIn == dmd_reqTagIn);
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_reqReadyIn) begin
                    state_s  = ST_WAIT;
                    to_cnt_s = {TO_W{1'b0}};
                end else begin
                    state_s  = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_hit_s) begin
                    state_s = ST_FILL;
                end else if (to_cnt_r == TO_LAST) begin
                    if (retry_r < RT_MAX) begin
                        state_s = ST_REQ;
                        retry_s = retry_r + RT_W'(1);
                    end else begin
                        state_s   = ST_IDLE;
                        retry_s   = {RT_W{1'b0}};
                        err_set_s = 1'b1;
                    end
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
                retry_s = {RT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Starvation counter: counts demand wins over a waiting prefetch.
        if (!pf_reqValidIn) begin
            starve_s = {ST_W{1'b0}};
        end else if (pick_p_s) begin
            starve_s = {ST_W{1'b0}};
        end else if (pick_d_s && !ack_s && (starve_r < ST_MAX)) begin
            starve_s = starve_r + ST_W'(1);
        end else begin
            starve_s = starve_r;
        end
    end

    // Sequencer state, latched request context and counters.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_r    <= ST_IDLE;
            tag_r      <= {TAG_WIDTH{1'b0}};
            src_pf_r   <= 1'b0;
            to_cnt_r   <= {TO_W{1'b0}};
            retry_r    <= {RT_W{1'b0}};
            starve_r   <= {ST_W{1'b0}};
            last_tag_r <= {TAG_WIDTH{1'b0}};
            ign_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            tag_r      <= tag_s;
            src_pf_r   <= src_pf_s;
            to_cnt_r   <= to_cnt_s;
            retry_r    <= retry_s;
            starve_r   <= starve_s;
            ign_r      <= (state_r == ST_FILL);
            last_tag_r <= (state_r == ST_FILL) ? tag_r : last_tag_r;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            pf_reqAckOut    <= 1'b0;
            mem_reqTagOut   <= {TAG_WIDTH{1'b0}};
            mem_reqValidOut <= 1'b0;
            fill_tagOut     <= {TAG_WIDTH{1'b0}};
            fill_lineOut    <= {LINE_WIDTH{1'b0}};
            fill_validOut   <= 1'b0;
            fill_isPfOut    <= 1'b0;
            busyOut         <= 1'b0;
            timeoutErrOut   <= 1'b0;
        end else begin
            pf_reqAckOut    <= ack_s;
            mem_reqValidOut <= (state_s == ST_REQ);
            mem_reqTagOut   <= (state_s == ST_REQ) ? tag_s : {TAG_WIDTH{1'b0}};
            fill_validOut   <= (state_s == ST_FILL);
            fill_tagOut     <= (state_s == ST_FILL) ? tag_r : {TAG_WIDTH{1'b0}};
            fill_lineOut    <= (state_s == ST_FILL) ? mem_rspLineIn : {LINE_WIDTH{1'b0}};
            fill_isPfOut    <= (state_s == ST_FILL) ? src_pf_r : 1'b0;
            busyOut         <= (state_s != ST_IDLE);
            timeoutErrOut   <= timeoutErrOut | err_set_s;
        end
    end

endmodule

// File: tb/tb_ifu_refill_arb.sv
module tb_ifu_refill_arb;

    logic         Clock;
    logic         Rst;
    logic [27:0]  dmd_reqTagIn;
    logic         dmd_reqValidIn;
    logic [27:0]  pf_reqTagIn;
    logic         pf_reqValidIn;
    logic         pf_reqAckOut;
    logic [27:0]  mem_reqTagOut;
    logic         mem_reqValidOut;
    logic         mem_reqReadyIn;
    logic [27:0]  mem_rspTagIn;
    logic [127:0] mem_rspLineIn;
    logic         mem_rspValidIn;
    logic [27:0]  fill_tagOut;
    logic [127:0] fill_lineOut;
    logic         fill_validOut;
    logic         fill_isPfOut;
    logic         busyOut;
    logic         timeoutErrOut;

    ifu_refill_arb dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .dmd_reqTagIn    (dmd_reqTagIn),
        .dmd_reqValidIn  (dmd_reqValidIn),
        .pf_reqTagIn     (pf_reqTagIn),
        .pf_reqValidIn   (pf_reqValidIn),
        .pf_reqAckOut    (pf_reqAckOut),
        .mem_reqTagOut   (mem_reqTagOut),
        .mem_reqValidOut (mem_reqValidOut),
        .mem_reqReadyIn  (mem_reqReadyIn),
        .mem_rspTagIn    (mem_rspTagIn),
        .mem_rspLineIn   (mem_rspLineIn),
        .mem_rspValidIn  (mem_rspValidIn),
        .fill_tagOut     (fill_tagOut),
        .fill_lineOut    (fill_lineOut),
        .fill_validOut   (fill_validOut),
        .fill_isPfOut    (fill_isPfOut),
        .busyOut         (busyOut),
        .timeoutErrOut   (timeoutErrOut)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          hs_cnt = 0;
    int          fill_cnt = 0;
    int          hs_cyc   [64];
    logic [27:0] hs_tag   [64];
    int          fill_cyc [64];
    logic [27:0] fill_tag [64];
    logic        fill_pf  [64];

    int          hs_seen = 0;
    bit          auto_rsp = 1'b0;
    bit          pf_auto = 1'b0;
    bit          dmd_auto = 1'b0;
    int          rsp_wait = 0;
    logic [27:0] rsp_tag_q = 28'h0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // cycle counter
    always @(posedge Clock) cyc <= cyc + 1;

    // record request handshakes and fill pulses mid-cycle
    always @(negedge Clock) begin
        if (mem_reqValidOut && mem_reqReadyIn) begin
            if (hs_cnt < 64) begin
                hs_cyc[hs_cnt] <= cyc;
                hs_tag[hs_cnt] <= mem_reqTagOut;
            end
            hs_cnt <= hs_cnt + 1;
        end
        if (fill_validOut) begin
            if (fill_cnt < 64) begin
                fill_cyc[fill_cnt] <= cyc;
                fill_tag[fill_cnt] <= fill_tagOut;
                fill_pf[fill_cnt]  <= fill_isPfOut;
            end
            fill_cnt <= fill_cnt + 1;
        end
    end

    function automatic logic [127:0] line_of(input logic [27:0] t);
        return {t, 4'hA, ~t, 4'h5, t, 4'hC, ~t, 4'h3};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; inputs change #1 after the edge. Also runs the optional
    // memory responder (answers 2 cycles after a handshake) and the
    // prefetcher/cache models that move on to a new tag once served.
    task automatic step();
        @(posedge Clock);
        #1;
        mem_rspValidIn = 1'b0;
        if (auto_rsp) begin
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    mem_rspValidIn = 1'b1;
                    mem_rspTagIn   = rsp_tag_q;
                    mem_rspLineIn  = line_of(rsp_tag_q);
                end
            end
            if (hs_cnt != hs_seen && hs_cnt > 0 && hs_cnt <= 64) begin
                rsp_tag_q = hs_tag[hs_cnt-1];
                rsp_wait  = 1;
            end
        end
        hs_seen = hs_cnt;
        if (pf_auto && pf_reqAckOut) pf_reqTagIn = pf_reqTagIn + 28'd1;
        if (dmd_auto && fill_validOut && !fill_isPfOut) dmd_reqTagIn = dmd_reqTagIn + 28'd1;
    endtask

    // Called right after the fill pulse: keep the demand through FILL->IDLE and
    // the first IDLE cycle (the cache's hit is still in flight), then drop it.
    task automatic finish_demand();
        step();
        step();
        dmd_reqValidIn = 1'b0;
        step();
    endtask

    task automatic wait_fill(input int budget);
        int k;
        k = 0;
        while (!fill_validOut && k < budget) begin
            step();
            k++;
        end
        check_eq("fill_within_budget", 128'(fill_validOut), 128'd1);
    endtask

    initial begin
        int c0, h0, f0, nf, k;
        logic       stable;
        logic [9:0] pat;

        Rst = 1'b0;
        dmd_reqTagIn = 28'h0; dmd_reqValidIn = 1'b0;
        pf_reqTagIn = 28'h0;  pf_reqValidIn = 1'b0;
        mem_reqReadyIn = 1'b0;
        mem_rspTagIn = 28'h0; mem_rspLineIn = 128'h0; mem_rspValidIn = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check_eq("rst_busy",   128'(busyOut), 128'd0);
        check_eq("rst_memv",   128'(mem_reqValidOut), 128'd0);
        check_eq("rst_fillv",  128'(fill_validOut), 128'd0);
        check_eq("rst_ack",    128'(pf_reqAckOut), 128'd0);
        check_eq("rst_err",    128'(timeoutErrOut), 128'd0);
        check_eq("rst_filll",  fill_lineOut, 128'd0);
        Rst = 1'b1;
        step();

        // ---------------- demand 0x12 alone, rsp 5 cycles after handshake ----------------
        h0 = hs_cnt; f0 = fill_cnt;
        dmd_reqTagIn = 28'h12; dmd_reqValidIn = 1'b1; mem_reqReadyIn = 1'b1;
        c0 = cyc;
        step();                       // IDLE grant
        check_eq("t1_req_valid", 128'(mem_reqValidOut), 128'd1);
        check_eq("t1_req_tag",   128'(mem_reqTagOut), 128'h12);
        step();                       // handshake
        for (int i = 0; i < 4; i++) step();
        mem_rspValidIn = 1'b1; mem_rspTagIn = 28'h12; mem_rspLineIn = line_of(28'h12);
        step();                       // response sampled 5 cycles after handshake
        check_eq("t1_fill_valid", 128'(fill_validOut), 128'd1);
        check_eq("t1_fill_tag",   128'(fill_tagOut), 128'h12);
        check_eq("t1_fill_line",  fill_lineOut, line_of(28'h12));
        check_eq("t1_fill_ispf",  128'(fill_isPfOut), 128'd0);
        finish_demand();
        check_eq("t1_fill_pulse_low", 128'(fill_validOut), 128'd0);
        for (int i = 0; i < 3; i++) step();
        check_eq("t1_hs_count",   128'(hs_cnt - h0), 128'd1);
        check_eq("t1_hs_tag",     128'(hs_tag[h0]), 128'h12);
        check_eq("t1_fill_count", 128'(fill_cnt - f0), 128'd1);
        check_eq("t1_latency",    128'(fill_cyc[f0] - c0 + 1), 128'd8);
        check_eq("t1_busy_end",   128'(busyOut), 128'd0);

        // ---------------- ready stall, then wrong-tag response ----------------
        h0 = hs_cnt; f0 = fill_cnt;
        mem_reqReadyIn = 1'b0;
        dmd_reqTagIn = 28'h12; dmd_reqValidIn = 1'b1;
        step();                       // grant
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable = stable & mem_reqValidOut & (mem_reqTagOut == 28'h12);
            step();
        end
        check_eq("t2_req_held_stable", 128'(stable), 128'd1);
        check_eq("t2_no_hs_while_stalled", 128'(hs_cnt - h0), 128'd0);
        mem_reqReadyIn = 1'b1;
        step();                       // handshake
        mem_rspValidIn = 1'b1; mem_rspTagIn = 28'h99; mem_rspLineIn = line_of(28'h99);
        step();
        check_eq("t2_wrong_tag_nofill", 128'(fill_validOut), 128'd0);
        check_eq("t2_wrong_tag_busy",   128'(busyOut), 128'd1);
        step(); step();
        mem_rspValidIn = 1'b1; mem_rspTagIn = 28'h12; mem_rspLineIn = line_of(28'h12);
        step();
        check_eq("t2_fill_valid", 128'(fill_validOut), 128'd1);
        check_eq("t2_fill_tag",   128'(fill_tagOut), 128'h12);
        check_eq("t2_fill_line",  fill_lineOut, line_of(28'h12));
        finish_demand();
        check_eq("t2_hs_count",   128'(hs_cnt - h0), 128'd1);
        check_eq("t2_fill_count", 128'(fill_cnt - f0), 128'd1);

        // ---------------- prefetch merges into in-flight demand 0x40 ----------------
        h0 = hs_cnt; f0 = fill_cnt;
        auto_rsp = 1'b1;
        dmd_reqTagIn = 28'h40; dmd_reqValidIn = 1'b1;
        step();                       // demand grant
        pf_reqTagIn = 28'h40; pf_reqValidIn = 1'b1;
        step();
        check_eq("t3_merge_ack", 128'(pf_reqAckOut), 128'd1);
        pf_reqValidIn = 1'b0;
        step();
        check_eq("t3_ack_pulse_low", 128'(pf_reqAckOut), 128'd0);
        wait_fill(20);
        check_eq("t3_fill_tag",  128'(fill_tagOut), 128'h40);
        check_eq("t3_fill_ispf", 128'(fill_isPfOut), 128'd0);
        finish_demand();
        for (int i = 0; i < 3; i++) step();
        check_eq("t3_hs_count",   128'(hs_cnt - h0), 128'd1);
        check_eq("t3_fill_count", 128'(fill_cnt - f0), 128'd1);

        // ---------------- starvation: D,D,D,D,P,D,D,D,D,P ----------------
        h0 = hs_cnt; f0 = fill_cnt;
        pf_auto = 1'b1; dmd_auto = 1'b1;
        dmd_reqTagIn = 28'h100; dmd_reqValidIn = 1'b1;
        pf_reqTagIn  = 28'h200; pf_reqValidIn  = 1'b1;
        nf = 0; k = 0;
        while (nf < 10 && k < 400) begin
            step();
            k++;
            if (fill_validOut) nf++;
            if (nf == 10) begin
                dmd_reqValidIn = 1'b0;
                pf_reqValidIn  = 1'b0;
            end
        end
        dmd_reqValidIn = 1'b0; pf_reqValidIn = 1'b0;
        pf_auto = 1'b0; dmd_auto = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("t4_fill_count", 128'(fill_cnt - f0), 128'd10);
        check_eq("t4_hs_count",   128'(hs_cnt - h0), 128'd10);
        pat = 10'd0;
        for (int i = 0; i < 10; i++) pat[i] = fill_pf[f0 + i];
        check_eq("t4_grant_order", 128'(pat), 128'h210);
        check_eq("t4_fill3_tag", 128'(fill_tag[f0 + 3]), 128'h103);
        check_eq("t4_fill4_tag", 128'(fill_tag[f0 + 4]), 128'h200);
        check_eq("t4_fill5_tag", 128'(fill_tag[f0 + 5]), 128'h104);
        check_eq("t4_fill9_tag", 128'(fill_tag[f0 + 9]), 128'h201);
        auto_rsp = 1'b0;

        // ---------------- no response: 3 requests 64 apart, then error ----------------
        check_eq("t5_err_before", 128'(timeoutErrOut), 128'd0);
        h0 = hs_cnt; f0 = fill_cnt;
        dmd_reqTagIn = 28'h55; dmd_reqValidIn = 1'b1; mem_reqReadyIn = 1'b1;
        step();                       // grant
        dmd_reqValidIn = 1'b0;
        k = 0;
        while (!timeoutErrOut && k < 400) begin
            step();
            k++;
        end
        check_eq("t5_err_set",    128'(timeoutErrOut), 128'd1);
        check_eq("t5_busy_after", 128'(busyOut), 128'd0);
        step(); step();
        check_eq("t5_err_sticky", 128'(timeoutErrOut), 128'd1);
        check_eq("t5_hs_count",   128'(hs_cnt - h0), 128'd3);
        check_eq("t5_gap1",       128'(hs_cyc[h0 + 1] - hs_cyc[h0]), 128'd64);
        check_eq("t5_gap2",       128'(hs_cyc[h0 + 2] - hs_cyc[h0 + 1]), 128'd64);
        check_eq("t5_retry_tag",  128'(hs_tag[h0 + 2]), 128'h55);
        check_eq("t5_no_fill",    128'(fill_cnt - f0), 128'd0);

        // ---------------- reset during WAIT, late response ignored ----------------
        f0 = fill_cnt;
        dmd_reqTagIn = 28'h12; dmd_reqValidIn = 1'b1;
        step();                       // grant
        step();                       // handshake
        dmd_reqValidIn = 1'b0;
        step();
        check_eq("t6_busy_in_wait", 128'(busyOut), 128'd1);
        Rst = 1'b0;
        step();
        check_eq("t6_rst_busy",  128'(busyOut), 128'd0);
        check_eq("t6_rst_memv",  128'(mem_reqValidOut), 128'd0);
        check_eq("t6_rst_err",   128'(timeoutErrOut), 128'd0);
        check_eq("t6_rst_fillv", 128'(fill_validOut), 128'd0);
        Rst = 1'b1;
        mem_rspValidIn = 1'b1; mem_rspTagIn = 28'h12; mem_rspLineIn = line_of(28'h12);
        step();
        step();
        check_eq("t6_late_nofill", 128'(fill_validOut), 128'd0);
        check_eq("t6_busy_idle",   128'(busyOut), 128'd0);
        check_eq("t6_fill_count",  128'(fill_cnt - f0), 128'd0);
        check_eq("t6_line_zero",   fill_lineOut, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
